instr_fetch_unit: RTL and testbench

//  Front end of the MIPS core: holds the PC, fetches each instruction from instruction

---
 rtl/mips_defs.sv | 15 +
 rtl/next_pc_calc.sv | 33 +++
 rtl/instr_fetch_unit.sv | 103 ++++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared PCSrc encodings and fetch FSM states
package mips_defs;

    localparam logic [1:0] PCSRC_SEQ = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_JR  = 2'd2;
    localparam logic [1:0] PCSRC_J   = 2'd3;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC select with misalignment flag
module next_pc_calc
    import mips_defs::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] addr26,
    input  logic [1:0]  pc_src,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    logic [31:0] br_offset;

    assign pc_plus4  = pc + 32'd4;
    // Sign-extend before the shift so negative offsets stay negative.
    assign br_offset = {{14{addr26[15]}}, addr26[15:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src)
            PCSRC_SEQ: next_pc = pc_plus4;
            PCSRC_BR:  next_pc = pc_plus4 + br_offset;
            PCSRC_JR:  next_pc = rs_data;
            PCSRC_J:   next_pc = {pc_plus4[31:28], addr26, 2'b00};
            default:   next_pc = pc_plus4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register, instruction fetch handshake and field decode
module instr_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemValid,
    input  logic [31:0] ImemData,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] RsData,
    input  logic        Commit,
    output logic        InstrValid,
    output logic [31:0] Instr,
    output logic [5:0]  Opcode,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [4:0]  Shamt,
    output logic [5:0]  Funct,
    output logic [15:0] Imm16,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        AddrErr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         addr_err_q, addr_err_d;
    logic [31:0]  next_pc;
    logic         misaligned;

    next_pc_calc u_next_pc_calc (
        .pc         (pc_q),
        .addr26     (instr_q[25:0]),
        .pc_src     (PCSrc),
        .rs_data    (RsData),
        .pc_plus4   (PCPlus4),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        addr_err_d = addr_err_q;
        case (state_q)
            ST_FETCH: begin
                if (ImemValid) begin
                    instr_d = ImemData;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (Commit) begin
                    if (misaligned) begin
                        addr_err_d = 1'b1;
                        state_d    = ST_FAULT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Request is masked while rst is held so it only appears once reset is released.
    assign ImemReq    = (state_q == ST_FETCH) && !rst;
    assign ImemAddr   = pc_q;
    assign InstrValid = (state_q == ST_EXEC);
    assign Instr      = instr_q;
    assign Opcode     = instr_q[31:26];
    assign Rs         = instr_q[25:21];
    assign Rt         = instr_q[20:16];
    assign Rd         = instr_q[15:11];
    assign Shamt      = instr_q[10:6];
    assign Funct      = instr_q[5:0];
    assign Imm16      = instr_q[15:0];
    assign PC         = pc_q;
    assign AddrErr    = addr_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - reference-model bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemValid;
    logic [31:0] ImemData;
    logic [1:0]  PCSrc;
    logic [31:0] RsData;
    logic        Commit;
    logic        InstrValid;
    logic [31:0] Instr;
    logic [5:0]  Opcode;
    logic [4:0]  Rs, Rt, Rd, Shamt;
    logic [5:0]  Funct;
    logic [15:0] Imm16;
    logic [31:0] PC, PCPlus4;
    logic        AddrErr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: waiting=0 (fetching), holding=1 (instruction available), dead=2 (faulted)
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_err;
    int          fetch_age;

    instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .rst(rst), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
        .ImemValid(ImemValid), .ImemData(ImemData), .PCSrc(PCSrc), .RsData(RsData),
        .Commit(Commit), .InstrValid(InstrValid), .Instr(Instr), .Opcode(Opcode),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct), .Imm16(Imm16),
        .PC(PC), .PCPlus4(PCPlus4), .AddrErr(AddrErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic [1:0] src, input logic [31:0] rs);
        logic [31:0] seq;
        int signed   off;
        seq = pc + 32'd4;
        off = int'($signed(ins[15:0])) * 4;
        case (src)
            2'd0:    return seq;
            2'd1:    return seq + 32'(off);
            2'd2:    return rs;
            default: return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        endcase
    endfunction

    task automatic compare_outputs();
        chk("ImemReq",    32'(ImemReq),    32'((m_phase == 0) && !rst));
        chk("ImemAddr",   ImemAddr,        m_pc);
        chk("PC",         PC,              m_pc);
        chk("PCPlus4",    PCPlus4,         m_pc + 32'd4);
        chk("InstrValid", 32'(InstrValid), 32'(m_phase == 1));
        chk("Instr",      Instr,           m_instr);
        chk("AddrErr",    32'(AddrErr),    32'(m_err));
        if (m_phase == 1) begin
            chk("Opcode", 32'(Opcode), 32'(m_instr >> 26));
            chk("Rs",     32'(Rs),     (m_instr >> 21) & 32'h1F);
            chk("Rt",     32'(Rt),     (m_instr >> 16) & 32'h1F);
            chk("Rd",     32'(Rd),     (m_instr >> 11) & 32'h1F);
            chk("Shamt",  32'(Shamt),  (m_instr >> 6) & 32'h1F);
            chk("Funct",  32'(Funct),  m_instr & 32'h3F);
            chk("Imm16",  32'(Imm16),  m_instr & 32'hFFFF);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d,
                        input logic c, input logic [1:0] s, input logic [31:0] rs);
        logic [31:0] nxt;
        rst = r; ImemValid = v; ImemData = d; Commit = c; PCSrc = s; RsData = rs;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0000_3000; m_instr = 32'd0; m_phase = 0; m_err = 1'b0; fetch_age = 0;
        end else if (m_phase == 0) begin
            fetch_age++;
            if (v) begin
                m_instr = d; m_phase = 1; fetch_age = 0;
            end
        end else if (m_phase == 1 && c) begin
            nxt = model_next(m_pc, m_instr, s, rs);
            if (nxt[1:0] != 2'b00) begin
                m_err = 1'b1; m_phase = 2;
            end else begin
                m_pc = nxt; m_phase = 0;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic fetch(input logic [31:0] d);
        idle();
        step(1'b0, 1'b1, d, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic commit(input logic [1:0] s, input logic [31:0] rs);
        step(1'b0, 1'b0, 32'h0, 1'b1, s, rs);
    endtask

    initial begin
        rst = 1'b1; ImemValid = 1'b0; ImemData = 32'd0; Commit = 1'b0; PCSrc = 2'd0; RsData = 32'd0;
        m_pc = 32'h0000_3000; m_instr = 32'd0; m_phase = 0; m_err = 1'b0; fetch_age = 0;
        @(negedge clk);

        // Reset state and first fetch with two-cycle memory latency
        step(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b1, 32'h1234_5678, 1'b1, 2'd3, 32'd0);
        chk("rst_req",   32'(ImemReq),    32'd0);
        chk("rst_ivld",  32'(InstrValid), 32'd0);
        chk("rst_pc",    PC,              32'h0000_3000);
        chk("rst_instr", Instr,           32'd0);
        idle();
        chk("req_rise",  32'(ImemReq),    32'd1);
        chk("addr0",     ImemAddr,        32'h0000_3000);
        idle();
        step(1'b0, 1'b1, 32'h8C43_0024, 1'b0, 2'd0, 32'd0);
        chk("ivld_rise", 32'(InstrValid), 32'd1);
        chk("opcode",    32'(Opcode),     32'h23);
        chk("funct",     32'(Funct),      32'h24);

        // Sequential, backward branch, then forward to 0x3008 and jump
        commit(2'd0, 32'd0);
        chk("seq_addr",  ImemAddr,        32'h0000_3004);
        chk("ivld_drop", 32'(InstrValid), 32'd0);
        fetch(32'h1000_FFFE);
        commit(2'd1, 32'd0);
        chk("br_back",   ImemAddr,        32'h0000_3000);
        fetch(32'h0);
        commit(2'd0, 32'd0);
        fetch(32'h0);
        commit(2'd0, 32'd0);
        chk("at_3008",   ImemAddr,        32'h0000_3008);
        fetch(32'h0800_0C10);
        commit(2'd3, 32'd0);
        chk("j_target",  ImemAddr,        32'h0000_3040);

        // Misaligned jr target faults and locks up until reset
        fetch(32'h0000_0008);
        commit(2'd2, 32'h0000_3102);
        chk("err_set",   32'(AddrErr),    32'd1);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'(i % 2), 32'h0, 1'b1, 2'd0, 32'd0);
            chk("fault_req", 32'(ImemReq), 32'd0);
        end
        chk("fault_pc",  PC,              32'h0000_3040);
        step(1'b1, 1'b0, 32'h0, 1'b0, 2'd0, 32'd0);
        chk("err_clr",   32'(AddrErr),    32'd0);
        idle();
        chk("refetch",   ImemAddr,        32'h0000_3000);

        // Commit during fetch and ImemValid during exec are ignored
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 2'd3, 32'h0);
        step(1'b0, 1'b1, 32'h0400_0010, 1'b0, 2'd0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 2'd0, 32'd0);
        chk("instr_hold", Instr,          32'h0400_0010);
        chk("pc_hold",    PC,             32'h0000_3000);

        // Reset beats a simultaneous jump
        step(1'b1, 1'b0, 32'h0, 1'b1, 2'd3, 32'd0);
        chk("rst_prio",  PC,              32'h0000_3000);
        idle();

        // Wrap at the top of the address space
        fetch(32'h0);
        commit(2'd2, 32'hFFFF_FFFC);
        chk("at_top",    ImemAddr,        32'hFFFF_FFFC);
        fetch(32'h0);
        commit(2'd0, 32'd0);
        chk("wrap",      ImemAddr,        32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic        r, v, c;
            logic [31:0] rs;
            r  = ($urandom_range(0, 99) == 0);
            if (m_phase == 0) v = (fetch_age > 0) && ($urandom_range(0, 2) == 0);
            else              v = ($urandom_range(0, 3) == 0);
            c  = ($urandom_range(0, 1) == 0);
            rs = $urandom();
            if ($urandom_range(0, 15) != 0) rs[1:0] = 2'b00;
            step(r, v, $urandom(), c, 2'($urandom_range(0, 3)), rs);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
